// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. It produces the current pixel
// coordinates, the horizontal and vertical sync pulses, a display-active flag,
// line and frame start strobes, and a free-running frame counter.
//
// The raster only advances on clk edges where pix_en is high. This lets the
// block run from a system clock that is faster than the pixel clock.
//
// Every output is a register, and the sync and display flags line up with
// the coordinates presented in the same cycle. To get that alignment, the
// flags are computed from the *next* coordinates, before the coordinate
// registers are loaded.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous reset, ACTIVE-HIGH despite the name
//                     (1 = reset); it takes priority over pix_en
//   pix_en       in   pixel-clock enable; the raster advances only when high
//   x            out  current column, 0 .. H_TOTAL-1
//   y            out  current line,   0 .. V_TOTAL-1
//   h_sync       out  horizontal sync, asserted at the H_POL level
//   v_sync       out  vertical sync, asserted at the V_POL level
//   display_on   out  high while x < H_DISPLAY and y < V_DISPLAY
//   line_start   out  one-clk pulse coincident with the new x = 0 of a line
//   frame_start  out  one-clk pulse coincident with the new (0,0) of a frame
//   frame_cnt    out  completed frames, modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int COORD_W   = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               h_sync,
    output logic               v_sync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // All compare points are folded to COORD_W-bit constants, so every
    // window test below is a plain unsigned compare against a constant.
    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_DISP_END   = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISP_END   = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] H_SYNC_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_SYNC_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    localparam logic H_ACT = (H_POL != 0);
    localparam logic V_ACT = (V_POL != 0);

    logic               x_wrap;
    logic               y_wrap;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               h_sync_next;
    logic               v_sync_next;
    logic               display_next;

    // Next raster position, assuming pix_en is high. y moves only when x
    // wraps, so a frame wrap is the case where x and y wrap on the same edge.
    always_comb begin
        x_wrap = (x == H_LAST);
        y_wrap = (y == V_LAST);
        x_next = x_wrap ? '0 : x + COORD_W'(1);
        y_next = y;
        if (x_wrap) begin
            y_next = y_wrap ? '0 : y + COORD_W'(1);
        end
    end

    // The flags are decoded from the next position, so they are registered
    // on the same edge as the coordinates they describe and have zero skew.
    always_comb begin
        h_sync_next  = ((x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST)) ? H_ACT : ~H_ACT;
        v_sync_next  = ((y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST)) ? V_ACT : ~V_ACT;
        display_next = (x_next < H_DISP_END) && (y_next < V_DISP_END);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            x           <= '0;
            y           <= '0;
            h_sync      <= ~H_ACT;
            v_sync      <= ~V_ACT;
            display_on  <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // Strobes default low so they last exactly one clk, even when
            // the following edges have pix_en low.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                x           <= x_next;
                y           <= y_next;
                h_sync      <= h_sync_next;
                v_sync      <= v_sync_next;
                display_on  <= display_next;
                line_start  <= x_wrap;
                frame_start <= x_wrap && y_wrap;
                if (x_wrap && y_wrap) begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

endmodule
